// File: rtl/key_gen_search.sv
// RSA-style key search: computes n = p*q, phi = (p-1)*(q-1), then walks odd public
// exponents from E_START until one is coprime to phi and derives d = e^-1 mod phi.

module kg_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    // Shift-add multiplier: fixed WIDTH-cycle latency; product holds after done.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make evaluation order change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            run     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= '0;
                mcand   <= {{WIDTH{1'b0}}, a};
                mplier  <= b;
                cnt     <= CW'(WIDTH);
                run     <= 1'b1;
            end else if (run) begin
                if (mplier[0])
                    product <= product + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

module kg_gcd #(
    parameter int N = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    output logic [N-1:0]        g,
    output logic signed [N-1:0] t,
    output logic                done
);
    logic [N-1:0]        r0, r1, quo, rem;
    logic signed [N-1:0] t0, t1, qt;
    logic                run;

    // Extended Euclid tracking only the b coefficient: s*a + t*b = gcd(a, b).
    // t stays within +/-a/2 when the gcd is 1, so it fits signed N bits.
    // NOTE: every always_comb output gets a value on all paths; a missed branch
    // would infer a latch.
    always_comb begin
        quo = '0;
        rem = '0;
        if (r1 != '0) begin
            quo = r0 / r1;
            rem = r0 % r1;
        end
        qt = $signed(quo) * t1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0   <= '0;
            r1   <= '0;
            t0   <= '0;
            t1   <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r0  <= a;
                r1  <= b;
                t0  <= '0;
                t1  <= {{(N-1){1'b0}}, 1'b1};
                run <= 1'b1;
            end else if (run) begin
                if (r1 == '0) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    r0 <= r1;
                    r1 <= rem;
                    t0 <= t1;
                    t1 <= t0 - qt;
                end
            end
        end
    end

    assign g = r0;
    assign t = t0;
endmodule

module key_gen_search #(
    parameter  int WIDTH     = 8,
    parameter  int E_START   = 3,
    parameter  int MAX_TRIES = 16,
    localparam int TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     p,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [WIDTH-1:0]     e,
    output logic [2*WIDTH-1:0]   d,
    output logic [2*WIDTH-1:0]   n,
    output logic [2*WIDTH-1:0]   phi,
    output logic [TW-1:0]        tries
);
    localparam int W2 = 2 * WIDTH;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_BAD   = 2'b01;
    localparam logic [1:0] ERR_TRIES = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;

    typedef enum logic [2:0] {
        IDLE, CHECK_IN, MULT, GCD_GO, GCD_WAIT, EVAL, FIN
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]     p_r, q_r;
    logic [W2-1:0]        phi_prod, n_prod, gcd_g, g_r;
    logic signed [W2-1:0] gcd_t, t_r;
    logic                 phi_done, n_done, seen_phi, seen_n;
    logic                 mult_start, gcd_start, gcd_done;
    logic                 in_bad, mult_both, e_ge_phi, gcd_ok, tries_max, e_ovf;
    logic [WIDTH:0]       e_sum;

    kg_mult #(.WIDTH(WIDTH)) u_mult_phi (
        .clk(clk), .rst_n(rst_n), .start(mult_start),
        .a(p_r - WIDTH'(1)), .b(q_r - WIDTH'(1)),
        .product(phi_prod), .done(phi_done)
    );

    kg_mult #(.WIDTH(WIDTH)) u_mult_n (
        .clk(clk), .rst_n(rst_n), .start(mult_start),
        .a(p_r), .b(q_r),
        .product(n_prod), .done(n_done)
    );

    kg_gcd #(.N(W2)) u_gcd (
        .clk(clk), .rst_n(rst_n), .start(gcd_start),
        .a(phi), .b({{WIDTH{1'b0}}, e}),
        .g(gcd_g), .t(gcd_t), .done(gcd_done)
    );

    assign in_bad    = (p_r < WIDTH'(2)) || (q_r < WIDTH'(2)) || (p_r == q_r);
    assign mult_both = (seen_phi || phi_done) && (seen_n || n_done);
    assign e_ge_phi  = {{WIDTH{1'b0}}, e} >= phi;
    assign gcd_ok    = g_r == W2'(1);
    assign tries_max = tries == TW'(MAX_TRIES);
    assign e_sum     = {1'b0, e} + (WIDTH+1)'(2);
    assign e_ovf     = e_sum[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = CHECK_IN;
            CHECK_IN: state_nxt = in_bad ? FIN : MULT;
            MULT:     if (mult_both) state_nxt = GCD_GO;
            GCD_GO:   state_nxt = e_ge_phi ? FIN : GCD_WAIT;
            GCD_WAIT: if (gcd_done) state_nxt = EVAL;
            EVAL:     state_nxt = (gcd_ok || tries_max || e_ovf) ? FIN : GCD_GO;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE) && (state != FIN);
        done       = state == FIN;
        mult_start = (state == CHECK_IN) && !in_bad;
        gcd_start  = (state == GCD_GO) && !e_ge_phi;
    end

    // Results are cleared on an accepted start and then only written by the step
    // that decides them, so they hold through done until the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r      <= '0;
            q_r      <= '0;
            err      <= ERR_OK;
            e        <= WIDTH'(E_START);
            d        <= '0;
            n        <= '0;
            phi      <= '0;
            tries    <= '0;
            seen_phi <= 1'b0;
            seen_n   <= 1'b0;
            g_r      <= '0;
            t_r      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    p_r      <= p;
                    q_r      <= q;
                    err      <= ERR_OK;
                    e        <= WIDTH'(E_START);
                    d        <= '0;
                    n        <= '0;
                    phi      <= '0;
                    tries    <= '0;
                    seen_phi <= 1'b0;
                    seen_n   <= 1'b0;
                end
                CHECK_IN: if (in_bad) err <= ERR_BAD;
                MULT: begin
                    seen_phi <= seen_phi || phi_done;
                    seen_n   <= seen_n || n_done;
                    if (mult_both) begin
                        phi   <= phi_prod;
                        n     <= n_prod;
                        e     <= WIDTH'(E_START);
                        tries <= '0;
                    end
                end
                GCD_GO: begin
                    if (e_ge_phi)
                        err <= ERR_RANGE;
                    else
                        tries <= tries + TW'(1);
                end
                GCD_WAIT: if (gcd_done) begin
                    g_r <= gcd_g;
                    t_r <= gcd_t;
                end
                EVAL: begin
                    if (gcd_ok)
                        d <= W2'(unsigned'(t_r)) + (t_r[W2-1] ? phi : '0);
                    else if (tries_max)
                        err <= ERR_TRIES;
                    else if (e_ovf)
                        err <= ERR_RANGE;
                    else
                        e <= e_sum[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_key_gen_search.sv
// Directed bench for key_gen_search: expected results are queued when a request is
// issued and popped when done pulses; a second instance runs with MAX_TRIES=2.

module tb_key_gen_search;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  p1 = '0, q1 = '0, p2 = '0, q2 = '0;
    logic        busy1, done1, busy2, done2;
    logic [1:0]  err1, err2;
    logic [7:0]  e1, e2;
    logic [15:0] d1, n1, phi1, d2, n2, phi2;
    logic [4:0]  tries1;
    logic [1:0]  tries2;

    key_gen_search dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .p(p1), .q(q1),
        .busy(busy1), .done(done1), .err(err1), .e(e1), .d(d1),
        .n(n1), .phi(phi1), .tries(tries1)
    );

    key_gen_search #(.MAX_TRIES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .p(p2), .q(q2),
        .busy(busy2), .done(done2), .err(err2), .e(e2), .d(d2),
        .n(n2), .phi(phi2), .tries(tries2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] err;
        int         e, d, n, phi, tries;
        bit         full;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int mult_starts = 0;

    always @(posedge clk) if (dut.mult_start) mult_starts++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] err, input int e, d, n, phi, tries,
                                input bit full);
        exp_t x;
        x.err = err; x.e = e; x.d = d; x.n = n; x.phi = phi; x.tries = tries; x.full = full;
        return x;
    endfunction

    function automatic int gcd_i(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Reference: plain Euclid for coprimality and a brute-force search for the inverse.
    function automatic exp_t model(input int pp, input int qq, input int maxt);
        exp_t x;
        int ph, ee;
        x = mk(2'd0, 3, 0, 0, 0, 0, 1'b1);
        if (pp < 2 || qq < 2 || pp == qq) begin
            x.err = 2'd1;
            x.full = 1'b0;
            return x;
        end
        ph = (pp - 1) * (qq - 1);
        x.n = pp * qq;
        x.phi = ph;
        ee = 3;
        for (int k = 0; k < 200; k++) begin
            if (ee >= ph) begin x.err = 2'd3; break; end
            x.tries++;
            if (gcd_i(ee, ph) == 1) begin
                for (int dd = 0; dd < ph; dd++)
                    if ((ee * dd) % ph == 1) x.d = dd;
                x.err = 2'd0;
                break;
            end
            if (x.tries == maxt) begin x.err = 2'd2; break; end
            if (ee + 2 > 255) begin x.err = 2'd3; break; end
            ee += 2;
        end
        x.e = ee;
        return x;
    endfunction

    task automatic issue(input int sel, input int pp, input int qq);
        @(negedge clk);
        if (sel == 1) begin p1 = 8'(pp); q1 = 8'(qq); start1 = 1'b1; end
        else          begin p2 = 8'(pp); q2 = 8'(qq); start2 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int sel, output int cycles);
        logic dn;
        cycles = 0;
        dn = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            dn = (sel == 1) ? done1 : done2;
            if (dn) break;
            @(negedge clk);
            cycles++;
        end
        if (!dn) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare(input int sel);
        exp_t x;
        logic [1:0] oe;
        int ee, od, on, op, ot;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        x = sb.pop_front();
        if (sel == 1) begin oe = err1; ee = e1; od = d1; on = n1; op = phi1; ot = tries1; end
        else          begin oe = err2; ee = e2; od = d2; on = n2; op = phi2; ot = tries2; end
        chk("err", 32'(oe), 32'(x.err));
        chk("d", od, x.d);
        chk("tries", ot, x.tries);
        if (x.full) begin
            chk("n", on, x.n);
            chk("phi", op, x.phi);
        end
        if (x.err == 2'd0) begin
            chk("e", ee, x.e);
            if (op != 0) chk("inv_ed_mod_phi", (ee * od) % op, 1);
        end
    endtask

    task automatic run(input int sel, input int pp, input int qq, input exp_t x,
                       output int cycles);
        sb.push_back(x);
        issue(sel, pp, qq);
        wait_done(sel, cycles);
        compare(sel);
    endtask

    task automatic check_reset_values();
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_e", 32'(e1), 32'd3);
        chk("rst_d", 32'(d1), 32'd0);
        chk("rst_n_out", 32'(n1), 32'd0);
        chk("rst_phi", 32'(phi1), 32'd0);
        chk("rst_tries", 32'(tries1), 32'd0);
    endtask

    initial begin
        int lat_a, lat_b, cyc, ms, dn_seen;
        bit hit;

        // Asynchronous reset takes effect before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_tries2", 32'(tries2), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(1, 11, 13, mk(2'd0, 7, 103, 143, 120, 3, 1'b1), lat_a);
        run(1, 5, 11, mk(2'd0, 3, 27, 55, 40, 1, 1'b1), cyc);
        run(1, 3, 5, mk(2'd0, 3, 3, 15, 8, 1, 1'b1), cyc);

        ms = mult_starts;
        run(1, 7, 7, mk(2'd1, 3, 0, 0, 0, 0, 1'b0), cyc);
        chk("no_mult_start_on_bad", mult_starts, ms);
        run(1, 1, 13, mk(2'd1, 3, 0, 0, 0, 0, 1'b0), cyc);

        run(2, 7, 11, mk(2'd2, 5, 0, 77, 60, 2, 1'b1), cyc);
        run(1, 7, 11, mk(2'd0, 7, 43, 77, 60, 3, 1'b1), cyc);
        run(1, 2, 3, mk(2'd3, 3, 0, 6, 2, 0, 1'b1), cyc);

        run(1, 17, 19, model(17, 19, 16), cyc);
        run(1, 13, 7, model(13, 7, 16), cyc);
        run(1, 251, 241, model(251, 241, 16), cyc);
        run(2, 13, 7, model(13, 7, 2), cyc);
        run(2, 31, 7, model(31, 7, 2), cyc);

        // Extra start pulses while busy must not disturb the running request.
        sb.push_back(mk(2'd0, 3, 27, 55, 40, 1, 1'b1));
        issue(1, 5, 11);
        for (int i = 0; i < 3; i++) begin
            p1 = 8'd7; q1 = 8'd7; start1 = 1'b1;
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("busy_during_req", 32'(busy1), 32'd1);
        wait_done(1, cyc);
        compare(1);
        dn_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1) dn_seen++;
        end
        chk("no_extra_done", dn_seen, 0);

        // Start during FIN is ignored; start held into the following cycle is taken.
        sb.push_back(mk(2'd0, 7, 103, 143, 120, 3, 1'b1));
        issue(1, 11, 13);
        wait_done(1, lat_b);
        compare(1);
        chk("latency_repeatable", lat_b, lat_a);
        p1 = 8'd3; q1 = 8'd5; start1 = 1'b1;
        @(negedge clk);
        chk("fin_start_ignored", 32'(busy1), 32'd0);
        @(negedge clk);
        start1 = 1'b0;
        chk("post_done_start_taken", 32'(busy1), 32'd1);
        sb.push_back(mk(2'd0, 3, 3, 15, 8, 1, 1'b1));
        wait_done(1, cyc);
        compare(1);

        // Reset while waiting on the gcd aborts silently.
        issue(1, 11, 13);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (dut.state == 3'd4) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        chk("reached_gcd_wait", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1) dn_seen++;
        end
        chk("no_done_after_abort", dn_seen, 0);
        run(1, 11, 13, mk(2'd0, 7, 103, 143, 120, 3, 1'b1), cyc);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_gen_search.md
KEY_GEN_SEARCH -- requirements
Module: key_gen_search

Interface
REQ-001 Parameter WIDTH, default 8: bit width of p, q and e; n, phi and d are 2*WIDTH bits.
REQ-002 Parameter E_START, default 3: first candidate public exponent; SHALL be odd and >= 3.
REQ-003 Parameter MAX_TRIES, default 16: maximum number of gcd attempts per request.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-007 p  input  WIDTH  prime 1, sampled on accepted start.
REQ-008 q  input  WIDTH  prime 2, sampled on accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle completion pulse (success or error).
REQ-011 err  output  2  00 ok, 01 bad input, 10 tries exhausted, 11 e reached phi or overflowed; valid with done, held until next accepted start.
REQ-012 e  output  WIDTH  public exponent found.
REQ-013 d  output  2*WIDTH  private exponent, 0 <= d < phi.
REQ-014 n  output  2*WIDTH  modulus p*q.
REQ-015 phi  output  2*WIDTH  (p-1)*(q-1).
REQ-016 tries  output  clog2(MAX_TRIES+1)  gcd attempts used by the last request.

Function
REQ-017 FSM states: IDLE, CHECK_IN, MULT, GCD_GO, GCD_WAIT, EVAL, FIN.
REQ-018 IDLE: start=1 -> register p, q into internal copies; go to CHECK_IN; busy rises next cycle.
REQ-019 start while not in IDLE SHALL be ignored with no effect on state or outputs.
REQ-020 CHECK_IN: p<2, q<2 or p==q -> err=01, FIN; else pulse start to two Mult instances ((p-1)*(q-1) and p*q), go to MULT.
REQ-021 MULT: wait until both Mult finish pulses have been seen (either order, same or different cycles); latch phi and n; set e=E_START, tries=0; go to GCD_GO.
REQ-022 GCD_GO: if e >= phi -> err=11, FIN; else one-cycle start pulse to gcd instance with a=phi, b=zero-extended e; tries += 1; go to GCD_WAIT.
REQ-023 GCD_WAIT: hold until gcd finish; latch gcd result and signed coefficient t; go to EVAL.
REQ-024 EVAL: gcd==1 -> d = t+phi if t negative (signed 2*WIDTH), else t; err=00; FIN.
REQ-025 EVAL: gcd!=1 and tries==MAX_TRIES -> err=10, FIN.
REQ-026 EVAL: gcd!=1, e+2 overflows WIDTH bits -> err=11, FIN; else e += 2, GCD_GO.
REQ-027 FIN: done=1 for exactly one cycle, busy=0 in that cycle, next state IDLE.
REQ-028 e, d, n, phi, tries, err SHALL hold their values after done until the next accepted start; on error d=0.
REQ-029 Latency from start to done for success = 2 + Mult latency + tries*(gcd latency + 3) + 1 cycles, deterministic for fixed inputs.
REQ-030 Result invariant on err=00: (e*d) mod phi == 1 and gcd(e,phi)==1.
REQ-031 start in the same cycle as done (FIN) SHALL be ignored; start the cycle after done SHALL be accepted.

Reset
REQ-032 rst_n low: state=IDLE, busy=0, done=0, err=00, e=E_START, d=0, n=0, phi=0, tries=0, gcd/Mult start pulses=0, immediately and regardless of clk.
REQ-033 Reset mid-request SHALL abort it with no done pulse; first start after release SHALL run normally.

Verification
REQ-034 WIDTH=8 defaults, p=11, q=13 -> done, err=00, n=143, phi=120, e=7, d=103, tries=3.
REQ-035 p=5, q=11 -> err=00, n=55, phi=40, e=3, d=27, tries=1; p=3, q=5 -> phi=8, e=3, d=3.
REQ-036 p=7, q=7 -> err=01, d=0, no Mult start issued; p=1, q=13 -> err=01.
REQ-037 MAX_TRIES=2, p=7, q=11 -> phi=60, e 3 and 5 rejected, err=10, tries=2, d=0; MAX_TRIES=16 same input -> e=7, d=43.
REQ-038 p=2, q=3 -> phi=2, err=11, tries=0; extra start pulses during busy ignored; rst_n low mid-GCD_WAIT -> outputs at reset values, no done, next request p=11, q=13 gives REQ-034 results.
